// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
// FSM encoding, command framing and synchroniser depth.
package spi_reg_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA
  } state_t;

  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_reg_bank_burst_sync.sv
// Brings cs_n/sclk/mosi into the clk domain and turns
// synced sclk edges into sample/drive pulses for the current mode.
module spi_edge_sync
  import spi_reg_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cs_n,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_cpol,
  input  logic i_cpha,
  output logic o_cs_n,
  output logic o_mosi,
  output logic o_sample,
  output logic o_drive,
  output logic o_cs_fall,
  output logic o_cs_rise
);
  logic [SYNC_DEPTH-1:0] r_cs;
  logic [SYNC_DEPTH-1:0] r_mosi;
  logic [SYNC_DEPTH:0]   r_sclk;
  logic                  r_cs_d;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_same;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cs   <= '1;
      r_cs_d <= 1'b1;
      r_sclk <= '0;
      r_mosi <= '0;
    end else begin
      r_cs   <= {r_cs[SYNC_DEPTH-2:0], i_cs_n};
      r_cs_d <= r_cs[SYNC_DEPTH-1];
      r_sclk <= {r_sclk[SYNC_DEPTH-1:0], i_sclk};
      r_mosi <= {r_mosi[SYNC_DEPTH-2:0], i_mosi};
    end
  end

  assign w_rise    = r_sclk[SYNC_DEPTH-1] & ~r_sclk[SYNC_DEPTH];
  assign w_fall    = ~r_sclk[SYNC_DEPTH-1] & r_sclk[SYNC_DEPTH];
  assign w_same    = (i_cpol == i_cpha);
  assign o_sample  = w_same ? w_rise : w_fall;
  assign o_drive   = w_same ? w_fall : w_rise;
  assign o_cs_n    = r_cs[SYNC_DEPTH-1];
  assign o_mosi    = r_mosi[SYNC_DEPTH-1];
  assign o_cs_fall = ~r_cs[SYNC_DEPTH-1] & r_cs_d;
  assign o_cs_rise = r_cs[SYNC_DEPTH-1] & ~r_cs_d;
endmodule

// File: rtl/spi_reg_bank_burst.sv
// SPI slave register bank: R/W config plus read-only status registers,
// run-time CPOL/CPHA, burst access with address auto-increment.
module spi_reg_bank_burst
  import spi_reg_pkg::*;
#(
  parameter int NUM_CFG  = 8,
  parameter int NUM_STAT = 8,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 7,
  parameter logic [WIDTH-1:0] CFG_RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_cs_n,
  input  logic                      spi_clk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  input  logic                      cpol,
  input  logic                      cpha,
  output logic [NUM_CFG*WIDTH-1:0]  config_regs,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*WIDTH-1:0] status_regs,
  output logic                      cfg_wr,
  output logic [ADDR_W-1:0]         cfg_wr_addr
);
  localparam int TOTAL = NUM_CFG + NUM_STAT;
  localparam int CNT_W = 6;
  localparam int RX_W  = (WIDTH > CMD_W) ? WIDTH : CMD_W;

  state_t            r_state;
  state_t            w_next;
  logic              r_cpol;
  logic              r_cpha;
  logic              w_cs_n_s;
  logic              w_mosi_s;
  logic              w_sample;
  logic              w_drive;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [RX_W-1:0]   r_rx;
  logic [RX_W-1:0]   w_rx_next;
  logic [WIDTH-1:0]  r_tx;
  logic [WIDTH-1:0]  w_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_addr_ld;
  logic              r_wr;
  logic              r_hold;
  logic              r_cfg_wr;
  logic [ADDR_W-1:0] r_cfg_wr_addr;
  logic [WIDTH-1:0]  r_cfg [NUM_CFG];
  logic              w_active;
  logic              w_cmd_done;
  logic              w_data_done;
  logic              w_frame_done;
  logic              w_in_cfg;
  logic              w_wr_en;

  spi_edge_sync u_sync (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_cs_n    (spi_cs_n),
    .i_sclk    (spi_clk),
    .i_mosi    (spi_mosi),
    .i_cpol    (r_cpol),
    .i_cpha    (r_cpha),
    .o_cs_n    (w_cs_n_s),
    .o_mosi    (w_mosi_s),
    .o_sample  (w_sample),
    .o_drive   (w_drive),
    .o_cs_fall (w_cs_fall),
    .o_cs_rise (w_cs_rise)
  );

  // Mode is frozen for the whole transaction once cs_n is seen low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
    end else if (w_cs_n_s) begin
      r_cpol <= cpol;
      r_cpha <= cpha;
    end
  end

  assign w_active    = (r_state != S_IDLE) && !w_cs_rise;
  assign w_cmd_done  = w_active && w_sample && (r_state == S_CMD)
                    && (r_bitcnt == CNT_W'(CMD_W-1));
  assign w_data_done = w_active && w_sample && (r_state == S_DATA)
                    && (r_bitcnt == CNT_W'(WIDTH-1));
  assign w_frame_done = w_cmd_done | w_data_done;
  assign w_in_cfg    = {1'b0, r_addr} < (ADDR_W+1)'(NUM_CFG);
  assign w_wr_en     = w_data_done & r_wr & w_in_cfg;
  assign w_rx_next   = {r_rx[RX_W-2:0], w_mosi_s};
  assign w_addr_inc  = (r_addr == ADDR_W'(TOTAL-1)) ? '0 : r_addr + 1'b1;
  assign w_addr_ld   = (r_state == S_CMD) ? w_rx_next[ADDR_W-1:0] : w_addr_inc;

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (w_addr_ld == ADDR_W'(i)) w_rd = r_cfg[i];
    for (int i = 0; i < NUM_STAT; i++)
      if (w_addr_ld == ADDR_W'(NUM_CFG+i))
        w_rd = status_regs[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_cs_fall) w_next = S_CMD;
      S_CMD: begin
        if (w_cs_rise)       w_next = S_IDLE;
        else if (w_cmd_done) w_next = S_DATA;
      end
      S_DATA: if (w_cs_rise) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The drive edge right after a load keeps the MSB on the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt      <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_addr        <= '0;
      r_wr          <= 1'b0;
      r_hold        <= 1'b0;
      r_cfg_wr      <= 1'b0;
      r_cfg_wr_addr <= '0;
    end else begin
      r_cfg_wr <= 1'b0;
      if (!w_active) begin
        r_bitcnt <= '0;
        r_rx     <= '0;
        r_tx     <= '0;
        r_addr   <= '0;
        r_wr     <= 1'b0;
        r_hold   <= 1'b0;
      end else begin
        if (w_sample) begin
          if (w_frame_done) begin
            r_bitcnt <= '0;
            r_rx     <= '0;
            r_tx     <= w_rd;
            r_hold   <= 1'b1;
            r_addr   <= w_addr_ld;
            if (w_cmd_done) r_wr <= w_rx_next[CMD_WR_BIT];
            if (w_wr_en) begin
              r_cfg_wr      <= 1'b1;
              r_cfg_wr_addr <= r_addr;
            end
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
            r_rx     <= w_rx_next;
          end
        end
        if (w_drive) begin
          if (r_hold) r_hold <= 1'b0;
          else        r_tx   <= {r_tx[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CFG; i++) r_cfg[i] <= CFG_RST_VAL;
    end else if (w_wr_en) begin
      for (int i = 0; i < NUM_CFG; i++)
        if (r_addr == ADDR_W'(i)) r_cfg[i] <= w_rx_next[WIDTH-1:0];
    end
  end

  for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
    assign config_regs[g*WIDTH +: WIDTH] = r_cfg[g];
  end

  assign spi_miso    = (r_state == S_DATA && !r_wr) ? r_tx[WIDTH-1] : 1'b0;
  assign spi_miso_oe = (r_state != S_IDLE);
  assign cfg_wr      = r_cfg_wr;
  assign cfg_wr_addr = r_cfg_wr_addr;
endmodule
